// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared definitions for the 8N1 receive UART.
//               - FSM state encoding (3-bit)
//               - Default bit period (100 MHz / 115200 baud)
//               - Default receive FIFO depth
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    // Same bit period as the transmit UART's 115200 baud setup.
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Small byte FIFO that buffers received bytes ahead of the
//               consumer. The head entry is always presented on rd_data.
//               A push while full is accepted only when a pop happens in
//               the same cycle; otherwise the push is ignored.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               push     - write wr_data
//               pop      - advance head (ignored while empty)
//               wr_data  - byte to write
//               full     - no free entry
//               empty    - no entry stored
//               rd_data  - head entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic [7:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    // One extra pointer bit separates the full and empty cases.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Asynchronous serial receiver, 8N1, LSB first. Delivers each
//               byte on a valid/ready interface and flags framing errors
//               (stop bit low) and overruns (byte lost or overwritten).
//               Build option: define UART_RX_FIFO_EN to buffer bytes in a
//               FIFO_DEPTH-entry FIFO instead of a single holding register.
// Ports       : clk_i      - system clock
//               reset_i    - asynchronous active-low reset
//               rxd_i      - serial input (asynchronous, idle high)
//               data_o     - received byte, meaningful while valid_o=1
//               valid_o    - byte available
//               ready_i    - consumer takes data_o when valid_o=1
//               busy_o     - frame in progress (state != IDLE)
//               frameErr_o - one-cycle pulse, stop bit sampled low
//               overrun_o  - one-cycle pulse, byte lost or overwritten
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frameErr_o,
    output logic       overrun_o
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    // Half-period load puts the first sample in the middle of the start bit.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_rx: CLKS_PER_BIT must be >= 4, FIFO_DEPTH a power of 2 >= 2");
    end

    logic             sync1;
    logic             rxs;
    rx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             frame_err;
    logic             overrun_q;
    logic             cnt_zero;
    logic             commit;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd_i;
            rxs   <= sync1;
        end
    end

    assign cnt_zero = (bit_cnt == '0);
    // Valid stop bit: the assembled byte is handed to the output stage.
    assign commit   = (state == STOP) && cnt_zero && rxs;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (!cnt_zero) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        bit_cnt <= HALF_LOAD;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        if (!rxs) begin
                            state   <= DATA;
                            bit_cnt <= FULL_LOAD;
                            bit_idx <= '0;
                        end else begin
                            // Line went back high before mid-bit: glitch.
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        // LSB arrives first, so shift in from the top.
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (cnt_zero) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not decode as 0x00 bytes.
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = (state != IDLE);
    assign frameErr_o = frame_err;
    assign overrun_o  = overrun_q;

`ifdef UART_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign fifo_pop = ready_i & ~fifo_empty;

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (reset_i),
        .push    (commit),
        .pop     (fifo_pop),
        .wr_data (shreg),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (data_o)
    );

    assign valid_o = ~fifo_empty;

    // A pop in the same cycle frees the slot, so only a blocked push drops.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= commit & fifo_full & ~fifo_pop;
        end
    end
`else
    logic [7:0] data_q;
    logic       valid_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Overwriting an unconsumed byte loses it.
            overrun_q <= commit & valid_q & ~ready_i;
            if (commit) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`endif

endmodule

`default_nettype wire
